bus_dest_decoder: RTL and testbench

//  Receive end of the datapath bus. The source side encodes one of 24 sources (R0-R15, HI, LO,

---
 rtl/bus_dest_decoder_pkg.sv | 47 ++++
 rtl/dest_decoder_5to32.sv | 12 +
 rtl/bus_dest_decoder.sv | 119 +++++++++++
 tb/tb_bus_dest_decoder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/bus_dest_decoder_pkg.sv
// Shared numbering for the datapath bus: source/destination codes, FSM states
// and the writable-destination predicate used by both encoder and decoder sides.
package bus_dest_decoder_pkg;

  localparam int unsigned CODE_W   = 5;
  localparam int unsigned NUM_DEST = 24;

  typedef logic [CODE_W-1:0] code_t;

  localparam code_t CODE_R0     = 5'd0;
  localparam code_t CODE_R1     = 5'd1;
  localparam code_t CODE_R2     = 5'd2;
  localparam code_t CODE_R3     = 5'd3;
  localparam code_t CODE_R4     = 5'd4;
  localparam code_t CODE_R5     = 5'd5;
  localparam code_t CODE_R6     = 5'd6;
  localparam code_t CODE_R7     = 5'd7;
  localparam code_t CODE_R8     = 5'd8;
  localparam code_t CODE_R9     = 5'd9;
  localparam code_t CODE_R10    = 5'd10;
  localparam code_t CODE_R11    = 5'd11;
  localparam code_t CODE_R12    = 5'd12;
  localparam code_t CODE_R13    = 5'd13;
  localparam code_t CODE_R14    = 5'd14;
  localparam code_t CODE_R15    = 5'd15;
  localparam code_t CODE_HI     = 5'd16;
  localparam code_t CODE_LO     = 5'd17;
  localparam code_t CODE_ZHIGH  = 5'd18;
  localparam code_t CODE_ZLOW   = 5'd19;
  localparam code_t CODE_PC     = 5'd20;
  localparam code_t CODE_MDR    = 5'd21;
  localparam code_t CODE_INPORT = 5'd22;
  localparam code_t CODE_C      = 5'd23;

  typedef enum logic [1:0] {
    IDLE,
    LATCH,
    COMMIT
  } state_t;

  // Z, InPort and C are driven by other units and are never bus destinations.
  function automatic logic code_is_writable(input code_t code, input int unsigned num_gpr);
    return (32'(code) < num_gpr) || (code == CODE_HI) || (code == CODE_LO) ||
           (code == CODE_PC) || (code == CODE_MDR);
  endfunction

endpackage

// File: rtl/dest_decoder_5to32.sv
// Combinational 5-to-32 one-hot decoder for destination codes.
module dest_decoder_5to32 (
  input  logic [4:0]  i_code,
  output logic [31:0] o_onehot
);

  always_comb begin
    o_onehot         = '0;
    o_onehot[i_code] = 1'b1;
  end

endmodule

// File: rtl/bus_dest_decoder.sv
// Receive end of the datapath bus: captures BusMuxOut on request, decodes the
// destination code, and loads the selected register after a LATCH/COMMIT walk.
module bus_dest_decoder
  import bus_dest_decoder_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_GPR = 16,
  parameter int unsigned CODE_W  = 5
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              wr_valid,
  input  logic [CODE_W-1:0] wr_code,
  output logic              wr_ready,
  output logic [23:0]       Rin,
  input  logic [CODE_W-1:0] rd_code,
  output logic [DATA_W-1:0] rd_data,
  output logic              err_sticky,
  output logic [CODE_W-1:0] err_code
);

  state_t              r_state;
  state_t              w_state_next;
  logic [DATA_W-1:0]   r_hold_data;
  logic [CODE_W-1:0]   r_hold_code;
  logic [23:0]         r_rin;
  logic                r_bad;
  logic                r_err_sticky;
  logic [CODE_W-1:0]   r_err_code;
  logic [DATA_W-1:0]   r_dest [NUM_DEST];
  logic [31:0]         w_dec;
  logic [31:0]         w_mask;
  logic                w_accept;
  logic [DATA_W-1:0]   w_rd_data;

  dest_decoder_5to32 u_dec (
    .i_code   (r_hold_code),
    .o_onehot (w_dec)
  );

  always_comb begin
    w_mask = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      w_mask[i] = code_is_writable(code_t'(i), NUM_GPR);
    end
  end

  always_comb begin
    w_state_next = r_state;
    wr_ready     = 1'b0;
    unique case (r_state)
      IDLE: begin
        wr_ready = 1'b1;
        if (wr_valid) w_state_next = LATCH;
      end
      LATCH:   w_state_next = COMMIT;
      COMMIT:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign w_accept = (r_state == IDLE) && wr_valid;

  // Load strobe is registered in LATCH so it is live for exactly the COMMIT cycle;
  // decode bits outside the writable set become the invalid-destination flag.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state      <= IDLE;
      r_hold_data  <= '0;
      r_hold_code  <= '0;
      r_rin        <= '0;
      r_bad        <= 1'b0;
      r_err_sticky <= 1'b0;
      r_err_code   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_hold_data <= BusMuxOut;
        r_hold_code <= wr_code;
      end
      if (r_state == LATCH) begin
        r_rin <= w_dec[23:0] & w_mask[23:0];
        r_bad <= |(w_dec & ~w_mask);
      end else begin
        r_rin <= '0;
        r_bad <= 1'b0;
      end
      if ((r_state == COMMIT) && r_bad) begin
        r_err_sticky <= 1'b1;
        if (!r_err_sticky) r_err_code <= r_hold_code;
      end
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int unsigned i = 0; i < NUM_DEST; i++) r_dest[i] <= '0;
    end else if (r_state == COMMIT) begin
      for (int unsigned i = 0; i < NUM_DEST; i++) begin
        if (r_rin[i]) r_dest[i] <= r_hold_data;
      end
    end
  end

  always_comb begin
    w_rd_data = '0;
    if (code_is_writable(code_t'(rd_code), NUM_GPR)) begin
      if ((r_state == COMMIT) && (rd_code == r_hold_code)) w_rd_data = r_hold_data;
      else                                                 w_rd_data = r_dest[rd_code];
    end
  end

  assign Rin        = r_rin;
  assign rd_data    = w_rd_data;
  assign err_sticky = r_err_sticky;
  assign err_code   = r_err_code;

endmodule

// File: tb/tb_bus_dest_decoder.sv
// Directed bench for bus_dest_decoder with hand-computed expectations.
module tb_bus_dest_decoder;

  logic        clock;
  logic        clear;
  logic [31:0] BusMuxOut;
  logic        wr_valid;
  logic [4:0]  wr_code;
  logic        wr_ready;
  logic [23:0] Rin;
  logic [4:0]  rd_code;
  logic [31:0] rd_data;
  logic        err_sticky;
  logic [4:0]  err_code;

  int checks = 0;
  int errors = 0;

  bus_dest_decoder #(.DATA_W(32), .NUM_GPR(16), .CODE_W(5)) dut (
    .clock      (clock),
    .clear      (clear),
    .BusMuxOut  (BusMuxOut),
    .wr_valid   (wr_valid),
    .wr_code    (wr_code),
    .wr_ready   (wr_ready),
    .Rin        (Rin),
    .rd_code    (rd_code),
    .rd_data    (rd_data),
    .err_sticky (err_sticky),
    .err_code   (err_code)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit tb_writable(input int c);
    return (c <= 17) || (c == 20) || (c == 21);
  endfunction

  // Called on a falling edge with the block idle; returns on the falling edge back in IDLE.
  task automatic do_write(input string tag, input logic [4:0] code, input logic [31:0] data,
                          input logic [23:0] exp_rin);
    chk({tag, " ready"}, {31'b0, wr_ready}, 32'd1);
    wr_valid  = 1'b1;
    wr_code   = code;
    BusMuxOut = data;
    @(posedge clock);
    @(negedge clock);
    wr_valid = 1'b0;
    chk({tag, " latch rin"}, {8'b0, Rin}, 32'd0);
    chk({tag, " latch ready"}, {31'b0, wr_ready}, 32'd0);
    @(negedge clock);
    chk({tag, " commit rin"}, {8'b0, Rin}, {8'b0, exp_rin});
    @(negedge clock);
    chk({tag, " idle rin"}, {8'b0, Rin}, 32'd0);
  endtask

  task automatic rd(input string tag, input logic [4:0] code, input logic [31:0] exp);
    rd_code = code;
    #1;
    chk(tag, rd_data, exp);
  endtask

  initial begin
    clear     = 1'b1;
    BusMuxOut = '0;
    wr_valid  = 1'b0;
    wr_code   = '0;
    rd_code   = '0;

    // Reset state and reset in the middle of COMMIT
    #1;
    chk("reset rin", {8'b0, Rin}, 32'd0);
    chk("reset err", {31'b0, err_sticky}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
    chk("post-reset ready", {31'b0, wr_ready}, 32'd1);
    wr_valid  = 1'b1;
    wr_code   = 5'd3;
    BusMuxOut = 32'hAAAA5555;
    @(posedge clock);
    @(negedge clock);
    wr_valid = 1'b0;
    @(negedge clock);
    chk("pre-clear commit rin", {8'b0, Rin}, 32'h8);
    clear = 1'b1;
    #1;
    chk("async clear rin", {8'b0, Rin}, 32'd0);
    @(negedge clock);
    clear = 1'b0;
    rd("R3 after clear", 5'd3, 32'd0);
    chk("ready after clear", {31'b0, wr_ready}, 32'd1);
    @(negedge clock);

    // Write R5 with forwarding during COMMIT
    rd_code   = 5'd5;
    wr_valid  = 1'b1;
    wr_code   = 5'd5;
    BusMuxOut = 32'hDEADBEEF;
    @(posedge clock);
    @(negedge clock);
    wr_valid  = 1'b0;
    BusMuxOut = 32'h0;
    chk("R5 latch rin", {8'b0, Rin}, 32'd0);
    chk("R5 latch rd", rd_data, 32'd0);
    @(negedge clock);
    chk("R5 commit rin", {8'b0, Rin}, 32'h20);
    chk("R5 commit fwd", rd_data, 32'hDEADBEEF);
    chk("R5 commit ready", {31'b0, wr_ready}, 32'd0);
    @(negedge clock);
    chk("R5 idle rin", {8'b0, Rin}, 32'd0);
    chk("R5 stored", rd_data, 32'hDEADBEEF);

    // Bus changes after acceptance do not affect the write
    wr_valid  = 1'b1;
    wr_code   = 5'd16;
    BusMuxOut = 32'h11111111;
    @(posedge clock);
    @(negedge clock);
    wr_valid  = 1'b0;
    BusMuxOut = 32'h22222222;
    @(negedge clock);
    chk("HI commit rin", {8'b0, Rin}, 32'h010000);
    @(negedge clock);
    rd("HI stored", 5'd16, 32'h11111111);

    // Invalid destinations
    do_write("inv19", 5'd19, 32'h33333333, 24'h0);
    chk("err sticky", {31'b0, err_sticky}, 32'd1);
    chk("err code 19", {27'b0, err_code}, 32'd19);
    do_write("inv30", 5'd30, 32'h44444444, 24'h0);
    chk("err code kept", {27'b0, err_code}, 32'd19);
    rd("rd code 19", 5'd19, 32'd0);
    rd("rd code 30", 5'd30, 32'd0);
    rd("R5 untouched", 5'd5, 32'hDEADBEEF);
    rd("HI untouched", 5'd16, 32'h11111111);

    // Back-pressure: wr_valid held high across two requests
    wr_valid  = 1'b1;
    wr_code   = 5'd20;
    BusMuxOut = 32'h100;
    @(posedge clock);
    @(negedge clock);
    wr_code   = 5'd21;
    BusMuxOut = 32'h200;
    chk("bp latch ready", {31'b0, wr_ready}, 32'd0);
    @(negedge clock);
    chk("bp PC rin", {8'b0, Rin}, 32'h100000);
    chk("bp commit ready", {31'b0, wr_ready}, 32'd0);
    @(negedge clock);
    chk("bp idle ready", {31'b0, wr_ready}, 32'd1);
    chk("bp idle rin", {8'b0, Rin}, 32'd0);
    @(negedge clock);
    chk("bp second latch ready", {31'b0, wr_ready}, 32'd0);
    chk("bp second latch rin", {8'b0, Rin}, 32'd0);
    @(negedge clock);
    chk("bp MDR rin", {8'b0, Rin}, 32'h200000);
    wr_valid = 1'b0;
    @(negedge clock);
    chk("bp ready final", {31'b0, wr_ready}, 32'd1);
    rd("PC stored", 5'd20, 32'h100);
    rd("MDR stored", 5'd21, 32'h200);

    // Sweep all codes
    for (int c = 0; c < 32; c++) begin
      logic [23:0] exp_rin;
      exp_rin = '0;
      if (tb_writable(c)) exp_rin[c] = 1'b1;
      do_write($sformatf("sweep%0d", c), 5'(c), 32'(c) * 32'h01010101, exp_rin);
    end
    for (int c = 0; c < 32; c++) begin
      rd($sformatf("sweep rd%0d", c), 5'(c), tb_writable(c) ? 32'(c) * 32'h01010101 : 32'd0);
    end
    chk("sweep err code", {27'b0, err_code}, 32'd19);
    chk("sweep err sticky", {31'b0, err_sticky}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
